float_add_sched: RTL
====================

Name: float_add_sched

Overview:
- Round-robin scheduler that shares one pipelined single-precision float adder between NREQ requesters.
- Accepts at most one operand pair per cycle and drives the adder's v1/v2 inputs.
- Tracks each issued operation's requester ID through the adder's fixed latency and returns the sum to the originating requester.
- Sits between the per-lane compute front ends and the single float_add instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ADD_LAT, 4, adder latency in cycles from registered v1/v2 to valid res (>=1).
- IDW, 2, requester ID width; must equal clog2(NREQ).

Ports:
- clk, input, 1, clock; all logic on rising edge.
- rst, input, 1, synchronous active-high reset.
- req_valid, input, NREQ, requester i has an operand pair.
- req_ready, output, NREQ, one-hot or zero; operation i accepted this cycle.
- req_v1, input, NREQ*32, operand 1 of requester i in bits [32i+31:32i].
- req_v2, input, NREQ*32, operand 2, packed the same way.
- add_v1, output, 32, registered operand to adder.
- add_v2, output, 32, registered operand to adder.
- add_res, input, 32, adder result.
- rsp_valid, output, NREQ, one-hot or zero; result for requester i.
- rsp_data, output, 32, result value, shared by all requesters.
- busy, output, 1, any operation in flight.

Behaviour:
- Reset values: req_ready=0, add_v1=0, add_v2=0, rsp_valid=0, rsp_data=0, busy=0, rr_ptr=0, pending[]=0, tag pipe cleared.
- Rule: at most one outstanding operation per requester. pending[i] sets on accept and clears when rsp_valid[i] is asserted.
- Eligibility: elig[i] = req_valid[i] & ~pending[i] & ~rst.
- Grant: combinational. Pick the first eligible index scanning rr_ptr, rr_ptr+1, ... mod NREQ.
  - req_ready = one-hot of the grant, or 0 if nothing is eligible.
  - A transfer occurs when req_valid[i] & req_ready[i].
- rr_ptr: on a transfer to i, becomes (i+1) mod NREQ next cycle. Unchanged when there is no transfer.
- Issue (cycle T = accept cycle):
  - At T+1, add_v1/add_v2 hold the granted operands.
  - If no transfer, they hold their previous values and the valid tag is 0.
- Tag pipe: {valid, id} shift register of depth ADD_LAT+1. Its stage-0 entry is loaded at T+1, aligned with add_v1/add_v2.
- Response:
  - Tag exit aligns with add_res at T+1+ADD_LAT.
  - rsp_data and rsp_valid are registered: rsp_valid[id]=1 and rsp_data=add_res at cycle T+2+ADD_LAT, for exactly one cycle.
  - Otherwise rsp_valid=0 and rsp_data holds its last value.
- Latency: accept to response = ADD_LAT+2 cycles. Throughput: one op/cycle when different requesters alternate.
- Same requester: the earliest re-accept is the cycle of its rsp_valid. pending clears combinationally with the response for eligibility, giving back-to-back reuse.
- Simultaneous events: a response to i and a new request from i in the same cycle is allowed. pending clears and re-sets, and the grant follows normal rr order.
- busy = OR of tag pipe valid bits, OR of rsp-stage valid, OR of pending.
- Sign handling: operands are passed unmodified. No value inspection or rounding; arithmetic belongs to the adder.
- Reset mid-operation:
  - In-flight tags are cleared and their results are never delivered; no rsp_valid for them.
  - req_ready is forced to 0 during rst.
  - The adder's internal state is ignored.
- Parameter errors: if NREQ>2^IDW or ADD_LAT<1, elaboration fails.

Test Plan:
- Single op: rst released; req_valid[0]=1 with v1=0x3F800000, v2=0x40000000 at cycle 0 (adder model of ADD_LAT=4) -> req_ready[0]=1 at cycle 0; add_v1/add_v2 set at cycle 1; rsp_valid=4'b0001 with rsp_data=0x40400000 at cycle 6; busy low at cycle 7.
- All four valid at cycle 0 -> grants 0,1,2,3 on cycles 0..3; responses on rsp_valid one-hot 0001,0010,0100,1000 on cycles 6..9, each carrying the correct sum.
- Requester 2 holds req_valid continuously -> second accept occurs in the cycle its first rsp_valid[2] is high (cycle 6), not earlier; req_ready[2]=0 on cycles 1..5.
- Fairness/wrap: after a grant to 3, requesters 0 and 3 are valid -> 0 granted first (rr_ptr=0), then 3.
- Reset mid-flight: issue to 1 at cycle 0, assert rst at cycle 3 for 1 cycle -> no rsp_valid ever for that op; all outputs at reset values at cycle 4; a new op after reset completes with normal latency.
- Idle hold: no requests for 10 cycles after a response -> rsp_valid=0, rsp_data and add_v1/add_v2 unchanged, busy=0.

Source files
------------

// File: rtl/float_add_sched.sv
// float_add_sched: round-robin front end for one shared pipelined float adder.
// Up to NREQ requesters each own at most one in-flight operation. The
// requester ID of every issued operation travels alongside the adder through
// a tag shift register. When the tag leaves the pipe, the adder result is
// registered and returned to the requester that issued it.
module float_add_sched #(
    parameter int NREQ    = 4,
    parameter int ADD_LAT = 4,
    parameter int IDW     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_v1,
    input  logic [NREQ*32-1:0]   req_v2,
    output logic [31:0]          add_v1,
    output logic [31:0]          add_v2,
    input  logic [31:0]          add_res,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [31:0]          rsp_data,
    output logic                 busy
);

    // Reject configurations where the ID cannot address every requester,
    // or where the adder has no latency.
    if (NREQ > (1 << IDW) || ADD_LAT < 1) begin : g_bad_param
        $error("float_add_sched: NREQ must fit in IDW bits and ADD_LAT must be >= 1");
    end

    logic [IDW-1:0]  rr_ptr;
    logic [NREQ-1:0] pending;
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_id;
    logic            gnt_any;

    logic [ADD_LAT:0] tag_vld;
    logic [IDW-1:0]   tag_id [ADD_LAT+1];

    // A response in this cycle frees its requester immediately, so the same
    // lane can be re-accepted in the cycle its result is delivered.
    assign elig = req_valid & ~(pending & ~rsp_valid) & {NREQ{~rst}};

    // Round-robin pick: first eligible lane scanning upward from rr_ptr.
    always_comb begin
        int unsigned idx;
        gnt     = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!gnt_any && elig[idx]) begin
                gnt_any  = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = IDW'(idx);
            end
        end
    end

    assign req_ready = gnt;

    // Arbitration state, operand registers and the requester tag pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr  <= '0;
            pending <= '0;
            add_v1  <= '0;
            add_v2  <= '0;
            tag_vld <= '0;
            for (int k = 0; k <= ADD_LAT; k++) begin
                tag_id[k] <= '0;
            end
        end else begin
            pending <= (pending & ~rsp_valid) | gnt;
            if (gnt_any) begin
                rr_ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
                add_v1 <= req_v1[32*int'(gnt_id) +: 32];
                add_v2 <= req_v2[32*int'(gnt_id) +: 32];
            end
            tag_vld   <= {tag_vld[ADD_LAT-1:0], gnt_any};
            tag_id[0] <= gnt_id;
            for (int k = 1; k <= ADD_LAT; k++) begin
                tag_id[k] <= tag_id[k-1];
            end
        end
    end

    // Capture the adder result when its tag exits and steer it to its owner.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= '0;
            if (tag_vld[ADD_LAT]) begin
                rsp_valid[tag_id[ADD_LAT]] <= 1'b1;
                rsp_data                   <= add_res;
            end
        end
    end

    assign busy = (|tag_vld) | (|rsp_valid) | (|pending);

endmodule
